// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back front end.
package wb_pkg;

    localparam int unsigned WB_AW = 5;
    localparam int unsigned WB_DW = 32;

    // Index 0 is the hard-wired zero register; writes to it are dropped.
    localparam logic [WB_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [WB_AW-1:0] rd;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order write buffer for reg_writeback.
// Exposes every slot in age order (index 0 = oldest) for the pending and
// forward compares. Slot data is exported only when REG_WRITEBACK_FWD_EN is defined.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        push,
    input  wb_entry_t                   push_entry,
    input  logic                        pop,
    output wb_entry_t                   head,
    output logic                        full,
    output logic                        empty,
    output logic [DEPTH-1:0]            ent_valid,
    output logic [DEPTH-1:0][WB_AW-1:0] ent_rd
`ifdef REG_WRITEBACK_FWD_EN
    ,
    output logic [DEPTH-1:0][WB_DW-1:0] ent_data
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_q];

    // Next-state pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state; reset drops everything queued.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: slots beyond count are never visible.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_entry;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_view
        logic [PW-1:0] idx;
        assign idx          = rd_ptr_q + PW'(i);
        assign ent_valid[i] = (CW'(i) < count_q);
        assign ent_rd[i]    = mem[idx].rd;
`ifdef REG_WRITEBACK_FWD_EN
        assign ent_data[i]  = mem[idx].data;
`endif
    end

endmodule

// File: rtl/reg_writeback.sv
// Write-side front end of the 32x32 register file.
// Arbitrates ALU and load writes (load has priority), buffers them in order and
// drives one write per cycle into the register file, which commits on the falling
// edge. Optional macro REG_WRITEBACK_FWD_EN adds youngest-match forwarding outputs.
// AW/DW must match the widths of wb_pkg::wb_entry_t.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = WB_AW,
    parameter int unsigned DW    = WB_DW
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [DW-1:0]   alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_rd,
    input  logic [DW-1:0]   mem_data,
    input  logic [2*AW-1:0] rs_rt,
    output logic            rs_pending,
    output logic            rt_pending,
    output logic [AW-1:0]   rwd,
    output logic [DW-1:0]   wb_data,
    output logic            wb_idle
`ifdef REG_WRITEBACK_FWD_EN
    ,
    output logic [DW-1:0]   rs_fwd_data,
    output logic [DW-1:0]   rt_fwd_data,
    output logic            rs_fwd_valid,
    output logic            rt_fwd_valid
`endif
);

    logic                     full, empty;
    logic                     mem_fire, alu_fire, push;
    wb_entry_t                push_entry, head;
    logic [DEPTH-1:0]         ent_valid;
    logic [DEPTH-1:0][AW-1:0] ent_rd;
    logic [AW-1:0]            rs, rt;
`ifdef REG_WRITEBACK_FWD_EN
    logic [DEPTH-1:0][DW-1:0] ent_data;
`endif

    assign rs = rs_rt[2*AW-1:AW];
    assign rt = rs_rt[AW-1:0];

    // No pass-through when full: ready stays low even if a pop happens this edge.
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;
    assign mem_fire  = mem_valid && mem_ready;
    assign alu_fire  = alu_valid && alu_ready;

    // Select the winning request; writes to the zero register are accepted but dropped.
    always_comb begin
        push       = 1'b0;
        push_entry = '{rd: alu_rd, data: alu_data};
        if (mem_fire) begin
            push       = (mem_rd != REG_ZERO);
            push_entry = '{rd: mem_rd, data: mem_data};
        end else if (alu_fire) begin
            push       = (alu_rd != REG_ZERO);
        end
    end

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .push       (push),
        .push_entry (push_entry),
        .pop        (!empty),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .ent_valid  (ent_valid),
        .ent_rd     (ent_rd)
`ifdef REG_WRITEBACK_FWD_EN
        ,
        .ent_data   (ent_data)
`endif
    );

    // Output register: pop the head every edge the buffer held something.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rwd     <= REG_ZERO;
            wb_data <= '0;
        end else if (!empty) begin
            rwd     <= head.rd;
            wb_data <= head.data;
        end else begin
            rwd     <= REG_ZERO;
        end
    end

    assign wb_idle = empty && (rwd == REG_ZERO);

    // Pending compare over queued entries only; the output register commits
    // before the next rising edge so it never blocks a read.
    always_comb begin
        rs_pending = 1'b0;
        rt_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i] == rs) && (rs != REG_ZERO)) rs_pending = 1'b1;
            if (ent_valid[i] && (ent_rd[i] == rt) && (rt != REG_ZERO)) rt_pending = 1'b1;
        end
    end

`ifdef REG_WRITEBACK_FWD_EN
    // Youngest match wins: slots are in age order, so the last hit overrides.
    always_comb begin
        rs_fwd_data = '0;
        rt_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i] == rs)) rs_fwd_data = ent_data[i];
            if (ent_valid[i] && (ent_rd[i] == rt)) rt_fwd_data = ent_data[i];
        end
    end

    assign rs_fwd_valid = rs_pending;
    assign rt_fwd_valid = rt_pending;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios plus random traffic, all checked
// against a queue-based model of the write buffer and output register.
module tb_reg_writeback;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_rd, mem_rd, rwd;
    logic [31:0] alu_data, mem_data, wb_data;
    logic [9:0]  rs_rt;
    logic        rs_pending, rt_pending, wb_idle;
`ifdef REG_WRITEBACK_FWD_EN
    logic [31:0] rs_fwd_data, rt_fwd_data;
    logic        rs_fwd_valid, rt_fwd_valid;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: queued writes (oldest first) and the register-file write port.
    ent_t        q[$];
    logic [4:0]  out_rd;
    logic [31:0] out_data;

    always #5 CLK = ~CLK;

    reg_writeback #(
        .DEPTH(DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .rs_rt      (rs_rt),
        .rs_pending (rs_pending),
        .rt_pending (rt_pending),
        .rwd        (rwd),
        .wb_data    (wb_data),
        .wb_idle    (wb_idle)
`ifdef REG_WRITEBACK_FWD_EN
        ,
        .rs_fwd_data  (rs_fwd_data),
        .rt_fwd_data  (rt_fwd_data),
        .rs_fwd_valid (rs_fwd_valid),
        .rt_fwd_valid (rt_fwd_valid)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_fwd(input logic [4:0] r);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].rd == r) return q[i].data;
        end
        return 32'd0;
    endfunction

    // One clock cycle: drive at negedge, check just after, then advance the model at posedge.
    task automatic step(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic [9:0] rsrt);
        logic exp_mr, exp_ar;
        @(negedge CLK);
        mem_valid = mv;  mem_rd = mrd;  mem_data = md;
        alu_valid = av;  alu_rd = ard;  alu_data = ad;
        rs_rt     = rsrt;
        #1;
        exp_mr = (q.size() < DEPTH);
        exp_ar = exp_mr && !mv;
        check_eq("mem_ready", mem_ready, exp_mr);
        check_eq("alu_ready", alu_ready, exp_ar);
        check_eq("rwd", rwd, out_rd);
        check_eq("wb_data", wb_data, out_data);
        check_eq("wb_idle", wb_idle, (q.size() == 0) && (out_rd == 5'd0));
        check_eq("rs_pending", rs_pending, model_pending(rsrt[9:5]));
        check_eq("rt_pending", rt_pending, model_pending(rsrt[4:0]));
`ifdef REG_WRITEBACK_FWD_EN
        check_eq("rs_fwd_valid", rs_fwd_valid, model_pending(rsrt[9:5]));
        check_eq("rt_fwd_valid", rt_fwd_valid, model_pending(rsrt[4:0]));
        if (model_pending(rsrt[9:5])) check_eq("rs_fwd_data", rs_fwd_data, model_fwd(rsrt[9:5]));
        if (model_pending(rsrt[4:0])) check_eq("rt_fwd_data", rt_fwd_data, model_fwd(rsrt[4:0]));
`endif
        @(posedge CLK);
        // Pop uses the pre-edge buffer, then the accepted request is appended.
        if (q.size() > 0) begin
            ent_t e;
            e = q.pop_front();
            out_rd   = e.rd;
            out_data = e.data;
        end else begin
            out_rd = 5'd0;
        end
        if (mv && exp_mr) begin
            if (mrd != 5'd0) q.push_back('{rd: mrd, data: md});
        end else if (av && exp_ar) begin
            if (ard != 5'd0) q.push_back('{rd: ard, data: ad});
        end
    endtask

    task automatic idle(input logic [9:0] rsrt);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rsrt);
    endtask

    initial begin
        RST_N = 1'b0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        rs_rt = '0;
        out_rd = '0; out_data = '0;
        #12;
        check_eq("reset_rwd", rwd, 5'd0);
        check_eq("reset_wb_data", wb_data, 32'd0);
        check_eq("reset_wb_idle", wb_idle, 1'b1);
        @(negedge CLK);
        RST_N = 1'b1;

        // Single ALU write.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h55, {5'd3, 5'd0});
        idle({5'd3, 5'd0});
        idle({5'd3, 5'd0});
        check_eq("alu_single_rwd", rwd, 5'd3);
        check_eq("alu_single_data", wb_data, 32'h55);
        idle('0);
        idle('0);

        // Both producers at once: load first, ALU the next cycle.
        step(1'b1, 5'd4, 32'hA, 1'b1, 5'd5, 32'hB, {5'd4, 5'd5});
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hB, {5'd4, 5'd5});
        repeat (3) idle({5'd4, 5'd5});

        // Back-to-back loads across several pointer wraps.
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 5'(i), 32'(i * 17), 1'b0, 5'd0, 32'd0, {5'(i), 5'(i - 1)});
        end
        repeat (3) idle('0);

        // Two writes to the same register keep order.
        step(1'b1, 5'd7, 32'd1, 1'b0, 5'd0, 32'd0, {5'd7, 5'd0});
        step(1'b1, 5'd7, 32'd2, 1'b0, 5'd0, 32'd0, {5'd7, 5'd0});
        repeat (3) idle({5'd7, 5'd0});

        // Zero-register write is accepted but dropped.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, '0);
        repeat (2) idle('0);

        // Reset in the middle of a stream.
        step(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'd0, '0);
        step(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0, '0);
        step(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, '0);
        @(negedge CLK);
        mem_valid = 1'b0; alu_valid = 1'b0; rs_rt = {5'd3, 5'd2};
        #2 RST_N = 1'b0;
        #1;
        check_eq("midrst_rwd", rwd, 5'd0);
        check_eq("midrst_wb_data", wb_data, 32'd0);
        check_eq("midrst_wb_idle", wb_idle, 1'b1);
        check_eq("midrst_rs_pending", rs_pending, 1'b0);
        q.delete();
        out_rd = '0;
        out_data = '0;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) idle({5'd3, 5'd2});

        // Same register back to back; forwarding, when built, returns the youngest.
        step(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'd0, {5'd9, 5'd9});
        step(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0, {5'd9, 5'd9});
        repeat (2) idle({5'd9, 5'd9});

        // Random traffic with small register indices to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                 {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))});
        end
        repeat (3) idle('0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
